// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: FSM state encodings and the
//               16x-oversampling tick constants used by the receiver (and by
//               a future transmitter).
// Contents    : ST_IDLE/ST_START/ST_DATA/ST_PARITY/ST_STOP (3-bit codes),
//               MID_TICK, LAST_TICK, OVERSAMPLE, max_int() helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // FSM state encodings (explicit 3-bit width)
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    // Oversampling: 16 ticks per bit, start bit checked at its centre (tick 7)
    localparam int MID_TICK   = 7;
    localparam int LAST_TICK  = 15;
    localparam int OVERSAMPLE = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : rx_sync
// Description : Two-flop synchroniser for an asynchronous single-bit input.
//               Both flops load RESET_VAL while reset is low.
// Ports       : clock  in  system clock
//               reset  in  synchronous, active-low reset
//               d      in  asynchronous input
//               q      out synchronised output (2-cycle latency)
// Revision    : 1.0 - initial release
// ============================================================================
module rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_meta <= RESET_VAL;
            r_q    <= RESET_VAL;
        end else begin
            r_meta <= d;
            r_q    <= r_meta;
        end
    end

    assign q = r_q;

endmodule : rx_sync
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 16x-oversampled UART receiver. Deserialises
//               start / data (LSB first) / [parity] / stop frames and presents
//               each word with a one-clock rx_done strobe.
// Parameters  : N_DATA       data bits per frame (5..9)
//               N_TICKS_STOP ticks spent in the stop bit (16, 24 or 32)
//               PARITY_ODD   parity sense with parity enabled: 0 even, 1 odd
// Ports       : clock      in  system clock
//               reset      in  synchronous, active-low reset
//               rx         in  asynchronous serial line, idle high
//               tick       in  16x baud sample strobe, one clock wide
//               dout       out last received word, held until next frame
//               rx_done    out one-clock pulse per completed frame
//               frame_err  out stop bit sampled low on last frame
//               parity_err out parity mismatch on last frame
// Config      : define UART_RX_PARITY_EN to receive one parity bit after the
//               data bits; otherwise parity_err is constant 0.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int N_DATA       = 8,
    parameter int N_TICKS_STOP = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx,
    input  logic              tick,
    output logic [N_DATA-1:0] dout,
    output logic              rx_done,
    output logic              frame_err,
    output logic              parity_err
);

    // Tick counter must reach both LAST_TICK and the stop-bit length
    localparam int c_s_max = max_int(LAST_TICK, N_TICKS_STOP - 1);
    localparam int c_s_w   = $clog2(c_s_max + 1);
    localparam int c_n_w   = (N_DATA > 1) ? $clog2(N_DATA) : 1;

    localparam logic [c_s_w-1:0] c_s_mid  = c_s_w'(MID_TICK);
    localparam logic [c_s_w-1:0] c_s_last = c_s_w'(LAST_TICK);
    localparam logic [c_s_w-1:0] c_s_stop = c_s_w'(N_TICKS_STOP - 1);
    localparam logic [c_n_w-1:0] c_n_last = c_n_w'(N_DATA - 1);

    logic              w_rx_s;
    logic [2:0]        r_state;
    logic [c_s_w-1:0]  r_s;
    logic [c_n_w-1:0]  r_n;
    logic [N_DATA-1:0] r_b;
`ifdef UART_RX_PARITY_EN
    logic              r_par_lat;
`endif

    rx_sync #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clock (clock),
        .reset (reset),
        .d     (rx),
        .q     (w_rx_s)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_s        <= '0;
            r_n        <= '0;
            r_b        <= '0;
            dout       <= '0;
            rx_done    <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_lat  <= 1'b0;
`endif
        end else begin
            rx_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Start detection does not wait for a tick
                    if (!w_rx_s) begin
                        r_state <= ST_START;
                        r_s     <= '0;
                    end
                end

                ST_START: begin
                    if (tick) begin
                        if (r_s == c_s_mid) begin
                            // Still low at the start-bit centre: real frame.
                            // Counting 16 more ticks lands on each data centre.
                            if (!w_rx_s) begin
                                r_state <= ST_DATA;
                                r_s     <= '0;
                                r_n     <= '0;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                end

                ST_DATA: begin
                    if (tick) begin
                        if (r_s == c_s_last) begin
                            r_s <= '0;
                            r_b <= {w_rx_s, r_b[N_DATA-1:1]};
                            if (r_n == c_n_last) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= ST_PARITY;
`else
                                r_state <= ST_STOP;
`endif
                            end else begin
                                r_n <= r_n + 1'b1;
                            end
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                end

`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (tick) begin
                        if (r_s == c_s_last) begin
                            r_par_lat <= ((^r_b) ^ w_rx_s) != 1'(PARITY_ODD);
                            r_s       <= '0;
                            r_state   <= ST_STOP;
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                end
`endif

                ST_STOP: begin
                    if (tick) begin
                        if (r_s == c_s_stop) begin
                            // Framing-error frames still deliver their data
                            dout      <= r_b;
                            frame_err <= ~w_rx_s;
`ifdef UART_RX_PARITY_EN
                            parity_err <= r_par_lat;
`else
                            parity_err <= 1'b0;
`endif
                            rx_done   <= 1'b1;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_s <= r_s + 1'b1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed self-checking bench for uart_rx (N_DATA=8,
//               N_TICKS_STOP=16). tick is strobed every 4 clocks, so one bit
//               lasts 64 clocks. Parity frames are exercised when
//               UART_RX_PARITY_EN is defined (PARITY_ODD=0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rx    = 1'b1;
    logic       tick  = 1'b0;
    logic [7:0] dout;
    logic       rx_done;
    logic       frame_err;
    logic       parity_err;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;
    int d0;

    uart_rx #(
        .N_DATA       (8),
        .N_TICKS_STOP (16),
        .PARITY_ODD   (0)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .tick       (tick),
        .dout       (dout),
        .rx_done    (rx_done),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clock = ~clock;

    // One-clock tick every 4 clocks
    initial begin
        forever begin
            repeat (3) @(negedge clock);
            tick = 1'b1;
            @(negedge clock);
            tick = 1'b0;
        end
    end

    // Every clock with rx_done high counts, so a stretched pulse shows up
    always @(negedge clock) begin
        if (rx_done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (64) @(negedge clock);
    endtask

    // Bad stop bit is only held long enough to cover its centre sample
    task automatic send_frame(input logic [7:0] d, input logic stop_ok);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (stop_ok) begin
            drive_bit(1'b1);
        end else begin
            rx = 1'b0;
            repeat (40) @(negedge clock);
            rx = 1'b1;
            repeat (24) @(negedge clock);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic send_parity_frame(input logic [7:0] d, input logic par);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(par);
        drive_bit(1'b1);
    endtask
`endif

    initial begin
        logic [7:0] v3c;
        v3c = 8'h3C;

        // Reset state
        reset = 1'b0;
        rx    = 1'b1;
        repeat (4) @(negedge clock);
        check("reset_dout",       32'(dout),       32'h0);
        check("reset_rx_done",    32'(rx_done),    32'h0);
        check("reset_frame_err",  32'(frame_err),  32'h0);
        check("reset_parity_err", 32'(parity_err), 32'h0);
        reset = 1'b1;
        repeat (20) @(negedge clock);

        // 1. Good frame 0x55
        d0 = done_cnt;
        send_frame(8'h55, 1'b1);
        check("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
        check("t1_dout",        32'(dout),          32'h55);
        check("t1_frame_err",   32'(frame_err),     32'h0);
        check("t1_parity_err",  32'(parity_err),    32'h0);

        // 2. Short low glitch: rejected at start-bit centre
        d0 = done_cnt;
        rx = 1'b0;
        repeat (16) @(negedge clock);
        rx = 1'b1;
        repeat (128) @(negedge clock);
        check("t2_no_done", 32'(done_cnt - d0), 32'd0);
        check("t2_dout",    32'(dout),          32'h55);

        // 3. Stop bit low, then a good frame clears frame_err
        d0 = done_cnt;
        send_frame(8'hA3, 1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        check("t3_bad_done",      32'(done_cnt - d0), 32'd1);
        check("t3_bad_dout",      32'(dout),          32'hA3);
        check("t3_bad_frame_err", 32'(frame_err),     32'h1);
        d0 = done_cnt;
        send_frame(8'h0F, 1'b1);
        check("t3_good_done",      32'(done_cnt - d0), 32'd1);
        check("t3_good_dout",      32'(dout),          32'h0F);
        check("t3_good_frame_err", 32'(frame_err),     32'h0);

        // 4. Back-to-back 0x00 then 0xFF
        d0 = done_cnt;
        send_frame(8'h00, 1'b1);
        check("t4_first_done", 32'(done_cnt - d0), 32'd1);
        check("t4_first_dout", 32'(dout),          32'h00);
        send_frame(8'hFF, 1'b1);
        check("t4_both_done",  32'(done_cnt - d0), 32'd2);
        check("t4_second_dout", 32'(dout),         32'hFF);
        check("t4_frame_err",  32'(frame_err),     32'h0);

        // 5. Reset during data bit 4
        drive_bit(1'b1);
        d0 = done_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(v3c[i]);
        rx = v3c[4];
        repeat (32) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("t5_rst_dout",       32'(dout),       32'h0);
        check("t5_rst_rx_done",    32'(rx_done),    32'h0);
        check("t5_rst_frame_err",  32'(frame_err),  32'h0);
        check("t5_rst_parity_err", 32'(parity_err), 32'h0);
        repeat (3) @(negedge clock);
        rx    = 1'b1;
        reset = 1'b1;
        repeat (64) @(negedge clock);
        check("t5_partial_discarded", 32'(done_cnt - d0), 32'd0);
        d0 = done_cnt;
        send_frame(v3c, 1'b1);
        check("t5_done",      32'(done_cnt - d0), 32'd1);
        check("t5_dout",      32'(dout),          32'h3C);
        check("t5_frame_err", 32'(frame_err),     32'h0);
        check("t5_parity_err", 32'(parity_err),   32'h0);

`ifdef UART_RX_PARITY_EN
        // 6. Even parity on 0xA5 (four ones): parity bit 0 is correct
        d0 = done_cnt;
        send_parity_frame(8'hA5, 1'b0);
        check("t6_good_done",       32'(done_cnt - d0), 32'd1);
        check("t6_good_dout",       32'(dout),          32'hA5);
        check("t6_good_parity_err", 32'(parity_err),    32'h0);
        d0 = done_cnt;
        send_parity_frame(8'hA5, 1'b1);
        check("t6_bad_done",        32'(done_cnt - d0), 32'd1);
        check("t6_bad_dout",        32'(dout),          32'hA5);
        check("t6_bad_parity_err",  32'(parity_err),    32'h1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_uart_rx
`default_nettype wire
